// File: rtl/nibble_adder_sequencer.sv
// rtl/nibble_adder_sequencer.sv - multi-cycle WIDTH-bit add on a shared 4-bit adder, one nibble per clock
//
// Purpose:
//   Latches two WIDTH-bit operands and a carry-in, then steps the external
//   4-bit full adder through NIB = WIDTH/4 nibbles, least-significant first,
//   chaining the carry and assembling the result.  A start/busy/done
//   handshake frames each operation.
//
// Optional feature:
//   SUBTRACT_EN - when defined, sub=1 at start computes op_a - op_b by
//   latching ~op_b with a carry-in of 1.  When undefined, sub is ignored.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   start, op_a, op_b,   operation request and operands, sampled in IDLE only
//   cin, sub
//   adder_a/b/c0         nibble operands and carry driven to the shared adder
//   adder_s/c4           adder sum and carry-out (combinational from a/b/c0)
//   busy                 high while nibbles are being processed
//   done                 one-cycle pulse when sum/cout/ovf are valid
//   sum, cout, ovf       result, final carry-out, signed overflow

module nibble_adder_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic             sub,
    output logic [3:0]       adder_a,
    output logic [3:0]       adder_b,
    output logic             adder_c0,
    input  logic [3:0]       adder_s,
    input  logic             adder_c4,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [IDXW-1:0]  idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    // Effective B operand and carry-in captured on an accepted start.
    logic [WIDTH-1:0] b_d;
    logic             carry_d;

`ifdef SUBTRACT_EN
    always_comb begin
        b_d     = sub ? ~op_b : op_b;
        carry_d = sub ? 1'b1 : cin;
    end
`else
    logic unused_sub;
    assign unused_sub = sub;

    always_comb begin
        b_d     = op_b;
        carry_d = cin;
    end
`endif

    wire last_nib = (idx_q == IDXW'(NIB - 1));

    // Adder ports are idle (zero) outside RUN so the shared adder sees no
    // stale operands between operations.
    always_comb begin
        adder_a  = 4'd0;
        adder_b  = 4'd0;
        adder_c0 = 1'b0;
        if (state_q == S_RUN) begin
            adder_c0 = carry_q;
            for (int k = 0; k < NIB; k++) begin
                if (idx_q == IDXW'(k)) begin
                    adder_a = a_q[4*k +: 4];
                    adder_b = b_q[4*k +: 4];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= op_a;
                        b_q     <= b_d;
                        carry_q <= carry_d;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < NIB; k++) begin
                        if (idx_q == IDXW'(k)) begin
                            sum_q[4*k +: 4] <= adder_s;
                        end
                    end
                    carry_q <= adder_c4;
                    idx_q   <= idx_q + IDXW'(1);
                    if (last_nib) begin
                        cout_q  <= adder_c4;
                        // Final sum MSB is adder_s[3] on this edge; sum_q
                        // does not hold it yet.
                        ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                   (adder_s[3] != a_q[WIDTH-1]);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_adder_sequencer.sv
// tb/tb_nibble_adder_sequencer.sv - scoreboard bench for nibble_adder_sequencer

module tb_nibble_adder_sequencer;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic [3:0]   adder_a, adder_b, adder_s;
    logic         adder_c0, adder_c4;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    always #5 clk = ~clk;

    // Shared 4-bit full adder.
    assign {adder_c4, adder_s} = 5'(adder_a) + 5'(adder_b) + 5'(adder_c0);

    nibble_adder_sequencer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .cin     (cin),
        .sub     (sub),
        .adder_a (adder_a),
        .adder_b (adder_b),
        .adder_c0(adder_c0),
        .adder_s (adder_s),
        .adder_c4(adder_c4),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .ovf     (ovf)
    );

    typedef struct packed {
        logic [W-1:0]   sum;
        logic           cout;
        logic           ovf;
        logic [NIB-1:0] c0;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endfunction

    // Reference: whole-word arithmetic; carry into nibble k from the low 4k bits.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic s);
        exp_t         e;
        logic [W-1:0] be;
        logic         ce;
        longint       full;
        be = b;
        ce = c;
`ifdef SUBTRACT_EN
        if (s) begin
            be = ~b;
            ce = 1'b1;
        end
`else
        if (s) begin
            be = b;
        end
`endif
        full   = longint'(a) + longint'(be) + longint'(ce);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == be[W-1]) && (e.sum[W-1] != a[W-1]);
        for (int k = 0; k < NIB; k++) begin
            longint mask;
            mask = (longint'(1) << (4 * k)) - 1;
            e.c0[k] = ((((longint'(a) & mask) + (longint'(be) & mask) + longint'(ce)) >> (4 * k)) & 1) != 0;
        end
        return e;
    endfunction

    // Monitor: busy-cycle count and adder_c0 history per operation.
    int             busy_cnt = 0;
    logic [NIB-1:0] c0_got = '0;

    always @(posedge rst) begin
        busy_cnt = 0;
        c0_got   = '0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (busy) begin
                if (busy_cnt < NIB) c0_got[busy_cnt] = adder_c0;
                busy_cnt++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sum", sum, e.sum);
                    check("cout", cout, e.cout);
                    check("ovf", ovf, e.ovf);
                    check("adder_c0_seq", c0_got, e.c0);
                    check("busy_cycles", busy_cnt, NIB);
                    check("busy_in_done", busy, 0);
                end
                busy_cnt = 0;
                c0_got   = '0;
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s, input bit expect_accept);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        cin   = c;
        sub   = s;
        start = 1'b1;
        if (expect_accept) exp_q.push_back(model(a, b, c, s));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s);
        issue(a, b, c, s, 1'b1);
        wait_done();
        @(negedge clk);
    endtask

    initial begin
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_adder_ab", {adder_a, adder_b, adder_c0}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(16'h0007, 16'h0007, 1'b1, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0);

        // Starts during RUN and DONE are ignored.
        issue(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
        op_a  = 16'hFFFF;
        op_b  = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ignored_start_sum", sum, 16'h2345);
        @(negedge clk);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);

        // Reset in the 2nd RUN cycle discards the operation.
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_done", done, 0);
        check("midrun_rst_res", {sum, cout, ovf}, 0);
        check("midrun_rst_adder", {adder_a, adder_b, adder_c0}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        run_op(16'h0002, 16'h0003, 1'b0, 1'b0);
        check("post_rst_sum", sum, 16'h0005);

        // Subtract requests (effective only with SUBTRACT_EN).
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1);
`ifdef SUBTRACT_EN
        check("sub_5_7", {cout, sum}, {1'b0, 16'hFFFE});
`else
        check("sub_ignored_5_7", {cout, sum}, {1'b0, 16'h000C});
`endif
        run_op(16'h0009, 16'h0009, 1'b0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_adder_sequencer.md
Name: nibble_adder_sequencer

Overview:
- Multi-cycle controller that runs a WIDTH-bit add on the shared 4-bit full-adder datapath (fourbitFullAdder), one nibble per clock, least-significant nibble first.
- Latches the operands, drives the adder ports, chains the carry between nibbles and assembles the result.
- Reports completion with a start/busy/done handshake.
- Sits between the ALU control path and the single adder instance.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4; NIB = WIDTH/4 nibble steps.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request a new operation; sampled only in IDLE.
- op_a  input  WIDTH  operand A; sampled with start.
- op_b  input  WIDTH  operand B; sampled with start.
- cin  input  1  carry-in; sampled with start.
- sub  input  1  subtract request; sampled with start; only effective with SUBTRACT_EN.
- adder_a  output  4  nibble of A to the adder's a.
- adder_b  output  4  nibble of B (effective) to the adder's b.
- adder_c0  output  1  carry to the adder's c0.
- adder_s  input  4  adder sum s.
- adder_c4  input  1  adder carry c4.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result register.
- cout  output  1  final carry-out.
- ovf  output  1  signed overflow of the result.

Behaviour:
- Reset, asynchronous, any time including mid-RUN:
  - State goes to IDLE; nibble index = 0.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Operand/carry registers = 0; adder_a/b/c0 = 0.
  - Any partial operation is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - adder_a/b/c0 driven 0.
  - start=1 at a rising edge latches A=op_a, B=op_b, carry=cin, then goes to RUN with idx=0.
  - In the same edge: done=0; sum, cout and ovf clear to 0.
- RUN (busy=1):
  - Combinational drive: adder_a=A[4*idx+3:4*idx], adder_b=B[4*idx+3:4*idx], adder_c0=carry register.
  - Each edge: sum[4*idx+3:4*idx] <= adder_s; carry <= adder_c4; idx <= idx+1.
  - At idx=NIB-1 the edge also sets cout <= adder_c4 and ovf, then goes to DONE.
  - start is ignored throughout RUN.
- DONE:
  - done=1, busy=0, for exactly one cycle, then IDLE at the next edge.
  - start is ignored in DONE.
- Latency: start sampled at edge 0; nibble k is captured at edge k+1; done is high in the cycle after edge NIB (WIDTH=16: done in cycle 4 after the start edge).
- Throughput: one operation per NIB+2 cycles.
- Results: sum, cout and ovf hold their values from the DONE edge until the next accepted start or reset.
- Overflow: ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]), using the effective B and the final sum.
- Arithmetic: sum is the modulo-2^WIDTH result; no carry enters the next operation.
- adder_s/adder_c4 are assumed combinational from adder_a/b/c0 within one cycle; no registering on the adder side.

Optional Feature:
- Macro SUBTRACT_EN.
- Defined, when sub=1 at start:
  - Latch B = ~op_b and carry = 1 (cin ignored), so the result is op_a - op_b.
  - cout=1 means no borrow.
  - ovf uses the inverted B.
  - sub=0 gives normal add.
- Undefined: sub port present but ignored; always add with cin.

Test Plan:
- WIDTH=16, op_a=0x0007, op_b=0x0007, cin=1 -> after 4 RUN cycles done pulses once; sum=0x000F, cout=0, ovf=0; busy high exactly 4 cycles.
- op_a=0xFFFF, op_b=0x0001, cin=0 -> carry ripples through all nibbles; sum=0x0000, cout=1, ovf=0; adder_c0 observed 0,1,1,1 across the RUN cycles.
- op_a=0x7FFF, op_b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; op_a=0x8000, op_b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Start 0x1234+0x1111, then pulse start with 0xFFFF+0xFFFF during RUN and during DONE -> both ignored; sum=0x2345; a later start in IDLE is accepted and gives sum=0xFFFE, cout=1.
- Assert rst in the 2nd RUN cycle of 0x00FF+0x0001 -> busy, done, sum, cout and ovf go 0 immediately; no done pulse follows; a following start of 0x0002+0x0003 gives sum=0x0005.
- SUBTRACT_EN defined: op_a=0x0005, op_b=0x0007, sub=1 -> sum=0xFFFE, cout=0; op_a=0x0009, op_b=0x0009, sub=1 -> sum=0x0000, cout=1. Without the macro, the same first stimulus gives sum=0x000C, cout=0.
